// File: rtl/classifier_pkg.sv
// classifier_pkg: shared types and constants for the classifier accumulator.
//   PROD_W     - width of one signed product word and of the output score
//   ACC_W_DEF  - default internal accumulator width
//   state_t    - frame FSM states (ACCUM -> FINISH -> OUT -> ACCUM)
//   S32_MAX/MIN- saturation limits of the 32-bit signed score
package classifier_pkg;

  localparam int PROD_W    = 32;
  localparam int ACC_W_DEF = 40;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FINISH = 2'd1,
    OUT    = 2'd2
  } state_t;

  localparam logic signed [PROD_W-1:0] S32_MAX = 32'sh7fff_ffff;
  localparam logic signed [PROD_W-1:0] S32_MIN = 32'sh8000_0000;

endpackage

// File: rtl/sat_s40_to_s32.sv
// sat_s40_to_s32: combinational saturation of an ACC_W-bit signed value to a
// 32-bit signed value.
//   din  - ACC_W-bit signed input (ACC_W must exceed 32)
//   dout - din clipped to [S32_MIN, S32_MAX]
//   clip - 1 when din was outside the 32-bit range
module sat_s40_to_s32
  import classifier_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  din,
  output logic signed [PROD_W-1:0] dout,
  output logic                     clip
);

  // The value fits in 32 bits exactly when every bit from the 32-bit sign
  // position upward is a copy of the sign.
  logic [ACC_W-PROD_W:0] hi;
  assign hi = din[ACC_W-1:PROD_W-1];

  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    dout = din[PROD_W-1:0];
    clip = 1'b0;
    if (!(&hi) && (|hi)) begin
      clip = 1'b1;
      dout = din[ACC_W-1] ? S32_MIN : S32_MAX;
    end
  end

endmodule

// File: rtl/classifier_accum.sv
// classifier_accum: accumulates N_TERMS signed products per frame, adds a
// bias, saturates to 32 bits and presents the score with a sign-based class.
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - product stream handshake
//   in_product            - signed 32-bit product
//   in_last               - upstream frame marker, only cross-checked
//   bias                  - signed bias, sampled in FINISH
//   out_valid/out_ready   - score handshake
//   score/class_out/sat   - saturated result, score>=0 flag, clip flag
//   err                   - sticky in_last / term-count disagreement
module classifier_accum
  import classifier_pkg::*;
#(
  parameter int N_TERMS = 64,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_product,
  input  logic                     in_last,
  input  logic signed [PROD_W-1:0] bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [PROD_W-1:0] score,
  output logic                     class_out,
  output logic                     sat,
  output logic                     err
);

  localparam int CNT_W = $clog2(N_TERMS);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic               last_term;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   bias_ext;
  logic [ACC_W-1:0]   sum_biased;
  logic [PROD_W-1:0]  sat_score;
  logic               sat_clip;

  assign accept     = in_valid && in_ready;
  assign last_term  = (cnt == CNT_W'(N_TERMS - 1));
  assign prod_ext   = {{(ACC_W-PROD_W){in_product[PROD_W-1]}}, in_product};
  assign bias_ext   = {{(ACC_W-PROD_W){bias[PROD_W-1]}}, bias};
  assign sum_biased = acc + bias_ext;

  sat_s40_to_s32 #(.ACC_W(ACC_W)) u_sat (
    .din  (sum_biased),
    .dout (sat_score),
    .clip (sat_clip)
  );

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      score     <= '0;
      class_out <= 1'b0;
      sat       <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          // in_ready is held low in the first cycle out of reset and rises here.
          in_ready <= !(accept && last_term);
          if (accept) begin
            acc <= acc + prod_ext;
            if (in_last != last_term) err <= 1'b1;
            if (last_term) begin
              cnt   <= '0;
              state <= FINISH;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        FINISH: begin
          score     <= sat_score;
          class_out <= ~sat_score[PROD_W-1];
          sat       <= sat_clip;
          out_valid <= 1'b1;
          state     <= OUT;
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end

        default: begin
          state    <= ACCUM;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_classifier_accum.sv
// tb_classifier_accum: directed self-checking bench for classifier_accum with
// N_TERMS=4. Each scenario task drives stimulus and compares inline.
module tb_classifier_accum;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_product;
  logic               in_last;
  logic signed [31:0] bias;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] score;
  logic               class_out;
  logic               sat;
  logic               err;

  int n_cmp = 0;
  int n_bad = 0;

  classifier_accum #(.N_TERMS(4), .ACC_W(40)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_last    (in_last),
    .bias       (bias),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .score      (score),
    .class_out  (class_out),
    .sat        (sat),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Offer one product and return #1 after the edge that accepted it.
  task automatic send(input logic signed [31:0] p, input logic l);
    int guard = 0;
    in_valid   = 1'b1;
    in_product = p;
    in_last    = l;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready=%0b expected 1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Full frame: four terms (in_last on term last_pos), gap idle cycles
  // between terms, then latency, result and handshake checks.
  task automatic do_frame(input string name,
                          input logic signed [31:0] p0, input logic signed [31:0] p1,
                          input logic signed [31:0] p2, input logic signed [31:0] p3,
                          input int last_pos, input int gap,
                          input logic signed [31:0] b,
                          input logic signed [31:0] exp_score,
                          input logic exp_class, input logic exp_sat);
    logic signed [31:0] terms [4];
    terms[0] = p0; terms[1] = p1; terms[2] = p2; terms[3] = p3;
    bias = b;
    for (int i = 0; i < 4; i++) begin
      send(terms[i], (i + 1 == last_pos));
      if (i < 3) repeat (gap) @(posedge clk);
      if (i < 3 && gap > 0) #1;
    end
    // One edge after the final accept the FSM is in FINISH: no output yet.
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_finish: out_valid=%0b in_ready=%0b expected 0 0", name, out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_latency: out_valid=%0b expected 1", name, out_valid);
    end
    n_cmp++;
    if (score !== exp_score) begin
      n_bad++;
      $display("FAIL %s_score: score=%h expected %h", name, score, exp_score);
    end
    n_cmp++;
    if (class_out !== exp_class || sat !== exp_sat) begin
      n_bad++;
      $display("FAIL %s_flags: class_out=%0b sat=%0b expected %0b %0b",
               name, class_out, sat, exp_class, exp_sat);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_handshake: out_valid=%0b in_ready=%0b expected 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_product = '0; in_last = 1'b0;
    bias = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: in_ready=%0b out_valid=%0b err=%0b expected 0 0 0", in_ready, out_valid, err);
    end
    n_cmp++;
    if (score !== 32'sd0 || class_out !== 1'b0 || sat !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_result: score=%h class_out=%0b sat=%0b expected 0 0 0", score, class_out, sat);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: in_ready=%0b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;  // held high outside OUT: must have no effect
    do_frame("basic", 1, 2, 3, 4, 4, 0, 10, 32'sd20, 1'b1, 1'b0);
    do_frame("zero", 1, -1, 2, -2, 4, 0, 0, 32'sd0, 1'b1, 1'b0);
    do_frame("gaps", -3, 8, -2, 9, 4, 3, 0, 32'sd12, 1'b1, 1'b0);
    do_frame("negative", -7, -8, 2, 1, 4, 0, -3, -32'sd15, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    do_frame("sat_pos", 32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff,
             4, 0, 0, 32'sh7fffffff, 1'b1, 1'b1);
    do_frame("sat_neg", 32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000,
             4, 0, -1, 32'sh80000000, 1'b0, 1'b1);
    do_frame("edge_max", 32'sh7fffffff, 0, 0, 0, 4, 0, 0, 32'sh7fffffff, 1'b1, 1'b0);
    do_frame("edge_over", 32'sh7fffffff, 0, 0, 0, 4, 0, 1, 32'sh7fffffff, 1'b1, 1'b1);
    do_frame("edge_min", 32'sh80000000, 0, 0, 0, 4, 0, 0, 32'sh80000000, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back_stall();
    bias = 0;
    for (int i = 0; i < 4; i++) send(2, (i == 3));
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || score !== 32'sd8) begin
      n_bad++;
      $display("FAIL stall_entry: out_valid=%0b score=%h expected 1 %h", out_valid, score, 32'sd8);
    end
    in_valid = 1'b1; in_product = 100; in_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || score !== 32'sd8) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: out_valid=%0b in_ready=%0b score=%h expected 1 0 %h",
                 c, out_valid, in_ready, score, 32'sd8);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_release: out_valid=%0b in_ready=%0b expected 0 1", out_valid, in_ready);
    end
    do_frame("after_stall", 100, -50, 7, 3, 4, 0, 0, 32'sd60, 1'b1, 1'b0);
  endtask

  task automatic test_err();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clean: err=%0b expected 0", err);
    end
    do_frame("err_frame", 5, 5, 5, 5, 3, 0, -30, -32'sd10, 1'b0, 1'b0);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_set: err=%0b expected 1", err);
    end
    do_frame("err_next", 1, 1, 1, 1, 4, 0, 0, 32'sd4, 1'b1, 1'b0);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: err=%0b expected 1", err);
    end
  endtask

  task automatic test_reset_midframe();
    bias = 0;
    send(9, 1'b0);
    send(9, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0 || score !== 32'sd0) begin
      n_bad++;
      $display("FAIL midreset: in_ready=%0b out_valid=%0b err=%0b score=%h expected 0 0 0 0",
               in_ready, out_valid, err, score);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_frame("post_reset", 1, 1, 1, 1, 4, 0, 0, 32'sd4, 1'b1, 1'b0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_err: err=%0b expected 0", err);
    end
    // Reset while a result is pending in OUT: it must be dropped.
    for (int i = 0; i < 4; i++) send(50, (i == 3));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || score !== 32'sd0) begin
        n_bad++;
        $display("FAIL out_reset: out_valid=%0b score=%h expected 0 0", out_valid, score);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back_stall();
    test_err();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/classifier_accum.md
CLASSIFIER_ACCUM -- requirements
Module: classifier_accum

Interface
REQ-001 Parameter N_TERMS, default 64, meaning number of signed products per dot product; legal range 2..128.
REQ-002 Parameter ACC_W, default 40, meaning internal accumulator width in bits.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  product word valid.
REQ-006 in_ready  output  1  block accepts a product this cycle.
REQ-007 in_product  input  32  signed fixed-point product from the signed-by-pixel multiplier stage.
REQ-008 in_last  input  1  upstream marks final product of a frame (checked only, not used to terminate).
REQ-009 bias  input  32  signed bias, sampled in FINISH state.
REQ-010 out_valid  output  1  score valid.
REQ-011 out_ready  input  1  downstream accepts score.
REQ-012 score  output  32  signed saturated sum of products plus bias.
REQ-013 class_out  output  1  1 when score >= 0, else 0.
REQ-014 sat  output  1  score was clipped this frame.
REQ-015 err  output  1  sticky: in_last disagreed with term count.

Function
REQ-016 Block SHALL accept a product on any edge where in_valid and in_ready are both 1; in_valid gaps SHALL hold accumulator and count unchanged.
REQ-017 Products SHALL be sign-extended to ACC_W and summed exactly, with no truncation or wrap within a frame.
REQ-018 FSM SHALL have states ACCUM, FINISH, OUT; reset state ACCUM.
REQ-019 ACCUM: in_ready=1; on acceptance of term number N_TERMS, next state FINISH; term counter wraps to 0.
REQ-020 FINISH: in_ready=0; acc+sign-extended bias SHALL be saturated to [-2^31, 2^31-1] and registered into score, class_out, sat; next state OUT.
REQ-021 OUT: out_valid=1, in_ready=0; score/class_out/sat SHALL be stable until out_valid and out_ready are both 1, then accumulator clears and next state ACCUM.
REQ-022 Latency: out_valid SHALL rise on the second rising edge after the edge accepting the final term.
REQ-023 Throughput: in_ready SHALL return to 1 on the edge after output handshake; at most one frame in flight.
REQ-024 err SHALL set when in_last=1 is accepted on a term other than number N_TERMS, or in_last=0 on term N_TERMS; err clears only on reset.
REQ-025 Frame result SHALL be produced after N_TERMS terms regardless of in_last.
REQ-026 out_ready asserted outside OUT SHALL have no effect.

Reset
REQ-027 While rst_n=0 at a rising edge: state ACCUM, accumulator 0, counter 0, out_valid 0, score 0, class_out 0, sat 0, err 0; in_ready SHALL read 0 during reset, 1 the cycle after rst_n rises.
REQ-028 Reset mid-frame or in OUT SHALL discard partial sums and pending output without emitting out_valid.

Structure
REQ-029 Shared package classifier_pkg SHALL hold product width (32), ACC_W default, FSM state enum, and S32 max/min saturation constants.
REQ-030 Saturation SHALL be one combinational sub-module sat_s40_to_s32 (ACC_W-bit signed in, 32-bit out plus clip flag).
REQ-031 All registers SHALL be in clk domain with synchronous rst_n; no latches.

Verification (bench with N_TERMS=4)
REQ-032 Terms 1,2,3,4, bias 10, out_ready=1 -> score 20, class_out 1, sat 0, out_valid two edges after 4th accept.
REQ-033 Four terms 0x7FFFFFFF, bias 0 -> score 0x7FFFFFFF, sat 1, class_out 1.
REQ-034 Four terms 0x80000000, bias -1 -> score 0x80000000, sat 1, class_out 0.
REQ-035 out_ready held 0 for 5 cycles in OUT with in_valid=1 -> score stable, in_ready 0, no terms accepted; handshake then next frame accepted.
REQ-036 in_last=1 on term 3 of 4 -> err 1 and stays 1; score still emitted after term 4.
REQ-037 rst_n low for one edge after 2 terms accepted, then frame 1,1,1,1 bias 0 -> score 4, err 0.
